// File: rtl/ir_nec_rx_param.sv
// NEC IR receiver: decodes leader, data bits, stop mark and repeat codes from a raw pin.
// Latency: o_valid/o_err 4 clk after the stop-mark pin edge, o_repeat 3 clk after the repeat-mark pin edge.
// Backpressure: none; o_valid/o_repeat/o_err are single-cycle strobes, o_data holds the last good frame.
module ir_nec_rx_param #(
    parameter int CLK_HZ        = 50000000,
    parameter int DATA_BITS     = 32,
    parameter int RX_ACTIVE_LOW = 1,
    parameter int CHECK_INV     = 1,
    parameter int LEAD_MARK_US  = 9000,
    parameter int LEAD_SPACE_US = 4500,
    parameter int RPT_SPACE_US  = 2250,
    parameter int BIT_MARK_US   = 560,
    parameter int ZERO_SPACE_US = 560,
    parameter int ONE_SPACE_US  = 1690,
    parameter int TIMEOUT_US    = 12000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_ir_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_repeat,
    output logic                 o_err,
    output logic                 o_busy
);

    localparam int DIV = CLK_HZ / 1000000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = $clog2(DATA_BITS + 1);
    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
    localparam logic IDLE_LVL = (RX_ACTIVE_LOW != 0);
    localparam bit   INV_EN   = (CHECK_INV != 0) && (DATA_BITS == 32);
    localparam logic [IW-1:0]        STOP_IDX = IW'(DATA_BITS);
    localparam logic [DATA_BITS-1:0] LSB_ONE  = DATA_BITS'(1);

    // Acceptance windows are nominal -25% .. +25%, in microsecond ticks.
    localparam logic [15:0] LM_LO = 16'(LEAD_MARK_US * 3 / 4);
    localparam logic [15:0] LM_HI = 16'(LEAD_MARK_US * 5 / 4);
    localparam logic [15:0] LS_LO = 16'(LEAD_SPACE_US * 3 / 4);
    localparam logic [15:0] LS_HI = 16'(LEAD_SPACE_US * 5 / 4);
    localparam logic [15:0] RS_LO = 16'(RPT_SPACE_US * 3 / 4);
    localparam logic [15:0] RS_HI = 16'(RPT_SPACE_US * 5 / 4);
    localparam logic [15:0] BM_LO = 16'(BIT_MARK_US * 3 / 4);
    localparam logic [15:0] BM_HI = 16'(BIT_MARK_US * 5 / 4);
    localparam logic [15:0] ZS_LO = 16'(ZERO_SPACE_US * 3 / 4);
    localparam logic [15:0] ZS_HI = 16'(ZERO_SPACE_US * 5 / 4);
    localparam logic [15:0] OS_LO = 16'(ONE_SPACE_US * 3 / 4);
    localparam logic [15:0] OS_HI = 16'(ONE_SPACE_US * 5 / 4);
    localparam logic [15:0] TO_W  = 16'(TIMEOUT_US);

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, RPT_MARK, CHECK
    } state_t;

    state_t                state, state_nxt;
    logic                  sync1, sync2, mark, mark_d, rise, fall, tick, fail, inv_ok;
    logic [PW-1:0]         presc;
    logic [15:0]           width;
    logic [IW-1:0]         idx, idx_nxt;
    logic [DATA_BITS-1:0]  shift, shift_nxt, data_nxt;
    logic [31:0]           s32;
    logic                  valid_nxt, rpt_nxt, err_nxt;

    function automatic logic in_win(input logic [15:0] w, input logic [15:0] lo, input logic [15:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    assign mark   = sync2 ^ IDLE_LVL;
    assign rise   = mark & ~mark_d;
    assign fall   = ~mark & mark_d;
    assign tick   = (presc == DIV_LAST);
    assign s32    = 32'(shift);
    assign inv_ok = !INV_EN ||
                    ((s32[15:8] == ~s32[7:0]) && (s32[31:24] == ~s32[23:16]));

    // Pin synchroniser and previous-mark register for edge detection; reset to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= IDLE_LVL;
            sync2  <= IDLE_LVL;
            mark_d <= 1'b0;
        end else begin
            sync1  <= i_ir_rx;
            sync2  <= sync1;
            mark_d <= mark;
        end
    end

    // 1 us prescaler and saturating width counter that restarts on every mark/space edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            width <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (rise || fall)
                width <= '0;
            else if (tick && width != 16'hFFFF)
                width <= width + 16'd1;
        end
    end

    // Next-state, shift register and pulse decisions; any failure funnels into one error path.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        shift_nxt = shift;
        data_nxt  = o_data;
        valid_nxt = 1'b0;
        rpt_nxt   = 1'b0;
        err_nxt   = 1'b0;
        fail      = 1'b0;
        if (state != IDLE && width > TO_W) begin
            fail = 1'b1;
        end else begin
            case (state)
                IDLE:       if (rise) state_nxt = LEAD_MARK;
                LEAD_MARK:  if (fall) begin
                                if (in_win(width, LM_LO, LM_HI)) state_nxt = LEAD_SPACE;
                                else fail = 1'b1;
                            end
                LEAD_SPACE: if (rise) begin
                                if (in_win(width, LS_LO, LS_HI)) begin
                                    state_nxt = BIT_MARK;
                                    idx_nxt   = '0;
                                    shift_nxt = '0;
                                end else if (in_win(width, RS_LO, RS_HI)) begin
                                    state_nxt = RPT_MARK;
                                end else begin
                                    fail = 1'b1;
                                end
                            end
                BIT_MARK:   if (fall) begin
                                if (!in_win(width, BM_LO, BM_HI)) fail = 1'b1;
                                else if (idx == STOP_IDX)         state_nxt = CHECK;
                                else                              state_nxt = BIT_SPACE;
                            end
                BIT_SPACE:  if (rise) begin
                                if (in_win(width, ZS_LO, ZS_HI)) begin
                                    idx_nxt   = idx + IW'(1);
                                    state_nxt = BIT_MARK;
                                end else if (in_win(width, OS_LO, OS_HI)) begin
                                    shift_nxt = shift | (LSB_ONE << idx);
                                    idx_nxt   = idx + IW'(1);
                                    state_nxt = BIT_MARK;
                                end else begin
                                    fail = 1'b1;
                                end
                            end
                RPT_MARK:   if (fall) begin
                                if (in_win(width, BM_LO, BM_HI)) rpt_nxt = 1'b1;
                                else fail = 1'b1;
                                state_nxt = IDLE;
                            end
                CHECK:      begin
                                if (inv_ok) begin
                                    data_nxt  = shift;
                                    valid_nxt = 1'b1;
                                end else begin
                                    err_nxt = 1'b1;
                                end
                                state_nxt = IDLE;
                                idx_nxt   = '0;
                                shift_nxt = '0;
                            end
                default:    state_nxt = IDLE;
            endcase
        end
        if (fail) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            shift_nxt = '0;
            rpt_nxt   = 1'b0;
            err_nxt   = 1'b1;
        end
    end

    // State, datapath and registered output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            shift    <= '0;
            o_data   <= '0;
            o_valid  <= 1'b0;
            o_repeat <= 1'b0;
            o_err    <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            shift    <= shift_nxt;
            o_data   <= data_nxt;
            o_valid  <= valid_nxt;
            o_repeat <= rpt_nxt;
            o_err    <= err_nxt;
            o_busy   <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_ir_nec_rx_param.sv
// Bench for ir_nec_rx_param: three instances (32-bit with/without inverse check sharing one pin, 16-bit at 50 MHz).
// Timings are scaled down so whole frames fit in a short run; outcomes come from a frame-level model.
// Pulses are counted by a monitor and compared per frame, including strobe latency from the pin edge.
module tb_ir_nec_rx_param;

    localparam int AB_DIV = 2;
    localparam int C_DIV  = 50;
    localparam int AB_LM = 225, AB_LS = 112, AB_RS = 56, AB_BM = 14, AB_ZS = 14, AB_OS = 42, AB_TO = 300;
    localparam int C_LM  = 90,  C_LS  = 45,  C_RS  = 22, C_BM  = 5,  C_ZS  = 5,  C_OS  = 16, C_TO  = 120;
    localparam int K_DATA = 0, K_RPT = 1, K_BADLEAD = 2, K_TRUNC = 3, K_STUCK = 4, K_GLITCH = 5;

    logic        clk = 1'b0;
    logic        rst_ab, rst_c, pin_ab, pin_c;
    logic [31:0] data_a, data_b;
    logic [15:0] data_c;
    logic        valid_a, rpt_a, err_a, busy_a;
    logic        valid_b, rpt_b, err_b, busy_b;
    logic        valid_c, rpt_c, err_c, busy_c;

    ir_nec_rx_param #(.CLK_HZ(2000000), .DATA_BITS(32), .RX_ACTIVE_LOW(1), .CHECK_INV(1),
        .LEAD_MARK_US(AB_LM), .LEAD_SPACE_US(AB_LS), .RPT_SPACE_US(AB_RS), .BIT_MARK_US(AB_BM),
        .ZERO_SPACE_US(AB_ZS), .ONE_SPACE_US(AB_OS), .TIMEOUT_US(AB_TO)) dut_a (
        .clk(clk), .rst(rst_ab), .i_ir_rx(pin_ab), .o_data(data_a), .o_valid(valid_a),
        .o_repeat(rpt_a), .o_err(err_a), .o_busy(busy_a));

    ir_nec_rx_param #(.CLK_HZ(2000000), .DATA_BITS(32), .RX_ACTIVE_LOW(1), .CHECK_INV(0),
        .LEAD_MARK_US(AB_LM), .LEAD_SPACE_US(AB_LS), .RPT_SPACE_US(AB_RS), .BIT_MARK_US(AB_BM),
        .ZERO_SPACE_US(AB_ZS), .ONE_SPACE_US(AB_OS), .TIMEOUT_US(AB_TO)) dut_b (
        .clk(clk), .rst(rst_ab), .i_ir_rx(pin_ab), .o_data(data_b), .o_valid(valid_b),
        .o_repeat(rpt_b), .o_err(err_b), .o_busy(busy_b));

    ir_nec_rx_param #(.CLK_HZ(50000000), .DATA_BITS(16), .RX_ACTIVE_LOW(0), .CHECK_INV(1),
        .LEAD_MARK_US(C_LM), .LEAD_SPACE_US(C_LS), .RPT_SPACE_US(C_RS), .BIT_MARK_US(C_BM),
        .ZERO_SPACE_US(C_ZS), .ONE_SPACE_US(C_OS), .TIMEOUT_US(C_TO)) dut_c (
        .clk(clk), .rst(rst_c), .i_ir_rx(pin_c), .o_data(data_c), .o_valid(valid_c),
        .o_repeat(rpt_c), .o_err(err_c), .o_busy(busy_c));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;
    int n_val[3], n_rpt[3], n_err[3], t_pulse[3];
    int excl_bad = 0, consec_bad = 0;
    logic [2:0]  prev_any = '0;
    logic [2:0]  mv, mr, me;
    logic [31:0] exp_dat[3];

    assign mv = {valid_c, valid_b, valid_a};
    assign mr = {rpt_c, rpt_b, rpt_a};
    assign me = {err_c, err_b, err_a};

    initial begin
        for (int i = 0; i < 3; i++) begin
            n_val[i] = 0; n_rpt[i] = 0; n_err[i] = 0; t_pulse[i] = 0; exp_dat[i] = '0;
        end
    end

    // Pulse monitor: counts strobes, remembers when the last one fired, flags overlap/back-to-back strobes.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mv[i]) n_val[i]++;
            if (mr[i]) n_rpt[i]++;
            if (me[i]) n_err[i]++;
            if (mv[i] | mr[i] | me[i]) t_pulse[i] = cyc;
            if (int'(mv[i]) + int'(mr[i]) + int'(me[i]) > 1) excl_bad++;
            if ((mv[i] | mr[i] | me[i]) && prev_any[i]) consec_bad++;
            prev_any[i] = mv[i] | mr[i] | me[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nom(input int w, input int k);
        case (k)
            0: return (w == 0) ? AB_LM : C_LM;
            1: return (w == 0) ? AB_LS : C_LS;
            2: return (w == 0) ? AB_RS : C_RS;
            3: return (w == 0) ? AB_BM : C_BM;
            4: return (w == 0) ? AB_ZS : C_ZS;
            5: return (w == 0) ? AB_OS : C_OS;
            default: return (w == 0) ? AB_TO : C_TO;
        endcase
    endfunction

    // Nominal duration with up to +/-10% random jitter.
    function automatic int jit(input int n);
        int j;
        j = n / 10;
        return n - j + int'($urandom_range(0, 2 * j));
    endfunction

    function automatic logic [31:0] dat(input int i);
        return (i == 0) ? data_a : (i == 1) ? data_b : {16'h0, data_c};
    endfunction

    function automatic logic bsy(input int i);
        return (i == 0) ? busy_a : (i == 1) ? busy_b : busy_c;
    endfunction

    // Frame-level reference: what a receiver with these settings must report for this frame.
    task automatic model(input int kind, input logic [31:0] b, input bit inv, input int dbits,
                         output int v, output int r, output int e);
        bit bad;
        v = 0; r = 0; e = 0;
        if (kind == K_DATA) begin
            bad = inv && (dbits == 32) && ((b[15:8] != ~b[7:0]) || (b[31:24] != ~b[23:16]));
            v = bad ? 0 : 1;
            e = bad ? 1 : 0;
        end else if (kind == K_RPT) begin
            r = 1;
        end else begin
            e = 1;
        end
    endtask

    // Drive mark (1) or space (0) on a pin group for a number of microseconds.
    task automatic seg(input int w, input bit m, input int us);
        if (w == 0) pin_ab = ~m;
        else        pin_c  = m;
        repeat (us * ((w == 0) ? AB_DIV : C_DIV)) @(negedge clk);
    endtask

    task automatic chk_busy(input int w, input string tag);
        if (w == 0) begin
            chk({tag, "_busy_a"}, bsy(0), 1);
            chk({tag, "_busy_b"}, bsy(1), 1);
        end else begin
            chk({tag, "_busy_c"}, bsy(2), 1);
        end
    endtask

    // Emits one frame; ec returns the cycle of the last pin edge that the decoder reacts to.
    task automatic send(input int w, input int kind, input logic [31:0] bits, input int nbits,
                        input string tag, output int ec);
        int n;
        ec = cyc;
        if (kind == K_GLITCH) begin
            seg(w, 1'b1, 0); @(negedge clk); seg(w, 1'b0, 0); ec = cyc; return;
        end
        if (kind == K_STUCK) begin
            seg(w, 1'b1, nom(w, 6) + 20); seg(w, 1'b0, 0); ec = cyc; return;
        end
        seg(w, 1'b1, (kind == K_BADLEAD) ? int'(bits) : jit(nom(w, 0)));
        chk_busy(w, tag);
        if (kind == K_BADLEAD) begin
            seg(w, 1'b0, 0); ec = cyc; return;
        end
        if (kind == K_RPT) begin
            seg(w, 1'b0, jit(nom(w, 2))); seg(w, 1'b1, jit(nom(w, 3))); seg(w, 1'b0, 0);
            ec = cyc; return;
        end
        seg(w, 1'b0, jit(nom(w, 1)));
        n = (kind == K_TRUNC) ? 10 : nbits;
        for (int i = 0; i < n; i++) begin
            seg(w, 1'b1, jit(nom(w, 3)));
            if (kind == K_TRUNC && i == n - 1) begin
                seg(w, 1'b0, 0); ec = cyc; return;
            end
            seg(w, 1'b0, bits[i] ? jit(nom(w, 5)) : jit(nom(w, 4)));
        end
        seg(w, 1'b1, jit(nom(w, 3)));
        seg(w, 1'b0, 0);
        ec = cyc;
    endtask

    task automatic run(input int w, input int kind, input logic [31:0] bits, input string tag);
        int bv[3], br[3], be[3];
        int ec, d, lat, ev, er, ee, i0, i1;
        logic [31:0] b;
        d = (w == 0) ? AB_DIV : C_DIV;
        b = (w == 0 || kind == K_BADLEAD) ? bits : (bits & 32'h0000FFFF);
        for (int i = 0; i < 3; i++) begin
            bv[i] = n_val[i]; br[i] = n_rpt[i]; be[i] = n_err[i];
        end
        send(w, kind, b, (w == 0) ? 32 : 16, tag, ec);
        if (kind == K_TRUNC) repeat ((nom(w, 6) + 4) * d) @(negedge clk);
        else                 repeat (10 * d + 10) @(negedge clk);
        i0 = (w == 0) ? 0 : 2;
        i1 = (w == 0) ? 1 : 2;
        for (int i = i0; i <= i1; i++) begin
            model(kind, b, (i != 1), (i == 2) ? 16 : 32, ev, er, ee);
            if (ev == 1) exp_dat[i] = b;
            chk({tag, "_valid_cnt"}, n_val[i] - bv[i], ev);
            chk({tag, "_rpt_cnt"},   n_rpt[i] - br[i], er);
            chk({tag, "_err_cnt"},   n_err[i] - be[i], ee);
            chk({tag, "_data"},      dat(i), exp_dat[i]);
            chk({tag, "_busy_end"},  bsy(i), 0);
            lat = t_pulse[i] - ec;
            if (ev == 1 || (ee == 1 && kind == K_DATA))
                chk({tag, "_lat4"}, lat, 4);
            else if (er == 1 || kind == K_BADLEAD || kind == K_GLITCH)
                chk({tag, "_lat3"}, lat, 3);
            else if (kind == K_TRUNC)
                chk({tag, "_timeout_lat_ok"},
                    (lat >= nom(w, 6) * d && lat <= (nom(w, 6) + 2) * d + 6), 1);
        end
        repeat (20 * d) @(negedge clk);
    endtask

    initial begin
        repeat (120000) @(posedge clk);
        $display("FAIL watchdog: cycle budget expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  x, y;
        logic [31:0] p;
        int          bv0, bv1, be0, be1;
        rst_ab = 1'b1; rst_c = 1'b1; pin_ab = 1'b1; pin_c = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_data",  dat(i), 0);
            chk("rst_valid", mv[i], 0);
            chk("rst_rpt",   mr[i], 0);
            chk("rst_err",   me[i], 0);
            chk("rst_busy",  bsy(i), 0);
        end
        rst_ab = 1'b0; rst_c = 1'b0;
        repeat (20) @(negedge clk);

        fork
            begin
                run(0, K_DATA,    32'hCF30FF00, "valid");
                run(0, K_RPT,     32'h0,        "repeat");
                run(0, K_DATA,    32'hCE30FF00, "inv_mismatch");
                run(0, K_BADLEAD, 32'd150,      "short_lead");
                run(0, K_TRUNC,   32'hFFFFFFFF, "trunc");
                run(0, K_STUCK,   32'h0,        "stuck_mark");
                run(0, K_GLITCH,  32'h0,        "glitch");

                bv0 = n_val[0]; bv1 = n_val[1]; be0 = n_err[0]; be1 = n_err[1];
                p = $urandom;
                seg(0, 1'b1, jit(AB_LM)); seg(0, 1'b0, jit(AB_LS));
                for (int i = 0; i < 15; i++) begin
                    seg(0, 1'b1, jit(AB_BM));
                    seg(0, 1'b0, p[i] ? jit(AB_OS) : jit(AB_ZS));
                end
                seg(0, 1'b1, 5);
                rst_ab = 1'b1;
                @(negedge clk);
                rst_ab = 1'b0;
                seg(0, 1'b0, 0);
                for (int i = 0; i < 2; i++) begin
                    chk("midrst_data",  dat(i), 0);
                    chk("midrst_valid", mv[i], 0);
                    chk("midrst_rpt",   mr[i], 0);
                    chk("midrst_err",   me[i], 0);
                    chk("midrst_busy",  bsy(i), 0);
                    exp_dat[i] = '0;
                end
                repeat (400) @(negedge clk);
                chk("midrst_quiet_valid_a", n_val[0] - bv0, 0);
                chk("midrst_quiet_valid_b", n_val[1] - bv1, 0);
                chk("midrst_quiet_err_a",   n_err[0] - be0, 0);
                chk("midrst_quiet_err_b",   n_err[1] - be1, 0);
                run(0, K_DATA, 32'hCF30FF00, "after_rst");

                for (int k = 0; k < 5; k++) begin
                    x = 8'($urandom); y = 8'($urandom);
                    if ($urandom_range(0, 1) == 1) p = {~y, y, ~x, x};
                    else                           p = $urandom;
                    run(0, K_DATA, p, "rand_frame");
                end
                run(0, K_BADLEAD, 32'($urandom_range(20, 160)),  "rand_short_lead");
                run(0, K_BADLEAD, 32'($urandom_range(286, 298)), "rand_long_lead");
            end
            begin
                run(1, K_DATA, 32'h00001234, "c_fixed");
                run(1, K_DATA, 32'($urandom), "c_rand");
                run(1, K_RPT,  32'h0,         "c_repeat");
            end
        join

        chk("strobe_overlap", excl_bad, 0);
        chk("strobe_back_to_back", consec_bad, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
